// File: rtl/sysid_checker.sv
// Reads the system ID and build timestamp words over Avalon-MM and compares them.
// Optional macro SYSID_CHECK_AUTOSTART_EN launches one check right after reset release.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'hAA55AA55,
  parameter logic [31:0] EXPECTED_TS    = 32'h5D1BC64E,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    DONE
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic        read_q;
  logic        busy_q;
  logic        done_q;
  logic        id_ok_q;
  logic        ts_ok_q;
  logic        timeout_q;
  logic [31:0] id_value_q;
  logic [31:0] ts_value_q;
  logic [15:0] cnt_q;

  logic launch;
  logic in_phase;
  logic capture;
  logic expire;

`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) auto_q <= 1'b1;
    else       auto_q <= 1'b0;
  end

  assign launch = start | auto_q;
`else
  assign launch = start;
`endif

  always_comb begin
    in_phase = 1'b0;
    capture  = 1'b0;
    case (state_q)
      RD_ID, RD_TS:     in_phase = 1'b1;
      WAIT_ID, WAIT_TS: begin
        in_phase = 1'b1;
        capture  = avm_readdatavalid;
      end
      default: ;
    endcase
    // A response landing on the last allowed cycle wins over the timeout.
    expire = in_phase && (cnt_q == CNT_LAST) && !capture;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= BASE_ADDR;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (expire) begin
        state_q   <= DONE;
        read_q    <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        timeout_q <= 1'b1;
        id_ok_q   <= 1'b0;
        ts_ok_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (launch) begin
              state_q    <= RD_ID;
              addr_q     <= BASE_ADDR;
              read_q     <= 1'b1;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
              id_ok_q    <= 1'b0;
              ts_ok_q    <= 1'b0;
              timeout_q  <= 1'b0;
              id_value_q <= '0;
              ts_value_q <= '0;
            end
          end
          RD_ID, RD_TS: begin
            cnt_q <= cnt_q + 16'd1;
            if (!avm_waitrequest) begin
              read_q  <= 1'b0;
              state_q <= (state_q == RD_ID) ? WAIT_ID : WAIT_TS;
            end
          end
          WAIT_ID: begin
            if (capture) begin
              id_value_q <= avm_readdata;
              id_ok_q    <= (avm_readdata == EXPECTED_ID);
              state_q    <= RD_TS;
              addr_q     <= BASE_ADDR + 32'd4;
              read_q     <= 1'b1;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          WAIT_TS: begin
            if (capture) begin
              ts_value_q <= avm_readdata;
              ts_ok_q    <= (avm_readdata == EXPECTED_TS);
              state_q    <= DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: nominal, mismatch, stall, timeout and mid-check reset.
module tb_sysid_checker;

  localparam logic [31:0] ID_W = 32'hAA55AA55;
  localparam logic [31:0] TS_W = 32'h5D1BC64E;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        timeout;

  int n_checks = 0;
  int n_fails  = 0;

  sysid_checker #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock            (clk),
    .reset            (rst),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .id_value         (id_value),
    .ts_value         (ts_value),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full check against a latency-1 slave; the ID read is stalled for 'stall' cycles.
  task automatic run_check(input logic [31:0] idw, input logic [31:0] tsw, input int stall,
                           input logic exp_id_ok, input logic exp_ts_ok);
    avm_waitrequest = (stall > 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("rd_id_read", avm_read, 1'b1);
    chk("rd_id_addr", avm_address, 32'h0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_read_held", avm_read, 1'b1);
      chk("stall_addr_held", avm_address, 32'h0);
    end
    avm_waitrequest = 1'b0;
    tick();
    chk("id_read_dropped", avm_read, 1'b0);
    avm_readdatavalid = 1'b1;
    avm_readdata      = idw;
    tick();
    avm_readdatavalid = 1'b0;
    chk("rd_ts_read", avm_read, 1'b1);
    chk("rd_ts_addr", avm_address, 32'h4);
    chk("id_value", id_value, idw);
    chk("id_ok", id_ok, exp_id_ok);
    tick();
    chk("ts_read_dropped", avm_read, 1'b0);
    chk("no_early_done", done, 1'b0);
    avm_readdatavalid = 1'b1;
    avm_readdata      = tsw;
    tick();
    avm_readdatavalid = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b0);
    chk("timeout_clear", timeout, 1'b0);
    chk("ts_value", ts_value, tsw);
    chk("ts_ok", ts_ok, exp_ts_ok);
    chk("id_ok_final", id_ok, exp_id_ok);
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("ts_ok_held", ts_ok, exp_ts_ok);
  endtask

  initial begin
    rst               = 1'b1;
    start             = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    tick();
    tick();
    chk("rst_read", avm_read, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_id_ok", id_ok, 1'b0);
    chk("rst_ts_ok", ts_ok, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_id_value", id_value, 32'h0);
    chk("rst_ts_value", ts_value, 32'h0);
    chk("rst_addr", avm_address, 32'h0);
    rst = 1'b0;

`ifdef SYSID_CHECK_AUTOSTART_EN
    tick();
    chk("autostart_read", avm_read, 1'b1);
    chk("autostart_addr", avm_address, 32'h0);
    rst = 1'b1;
    tick();
    start = 1'b0;
    #1 rst = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    avm_waitrequest = 1'b0;
    tick();
`else
    tick();
    tick();
    chk("idle_without_start", busy, 1'b0);
    chk("no_read_without_start", avm_read, 1'b0);
`endif

    run_check(ID_W, TS_W, 0, 1'b1, 1'b1);
    run_check(ID_W, 32'h5D1BC64F, 0, 1'b1, 1'b0);
    run_check(ID_W, TS_W, 5, 1'b1, 1'b1);
    run_check(32'h12345678, TS_W, 0, 1'b0, 1'b1);

    // Silent slave: the ID phase expires after 8 cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("to_read_dropped", avm_read, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("to_not_yet", done, 1'b0);
    end
    tick();
    chk("to_done", done, 1'b1);
    chk("to_timeout", timeout, 1'b1);
    chk("to_id_ok", id_ok, 1'b0);
    chk("to_ts_ok", ts_ok, 1'b0);
    chk("to_busy", busy, 1'b0);
    chk("to_read", avm_read, 1'b0);
    start             = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata      = ID_W;
    tick();
    start = 1'b0;
    tick();
    avm_readdatavalid = 1'b0;
    chk("start_in_done_ignored", busy, 1'b0);
    chk("late_rdv_id_value", id_value, 32'h0);
    chk("late_rdv_id_ok", id_ok, 1'b0);
    chk("timeout_held", timeout, 1'b1);

    // Reset during WAIT_TS, then a stray response after release.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    avm_readdatavalid = 1'b1;
    avm_readdata      = ID_W;
    tick();
    avm_readdatavalid = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_read", avm_read, 1'b0);
    chk("mid_rst_id_ok", id_ok, 1'b0);
    chk("mid_rst_addr", avm_address, 32'h0);
    tick();
    rst = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata      = TS_W;
    tick();
    avm_readdatavalid = 1'b0;
    chk("abort_no_done", done, 1'b0);
    chk("stray_ts_value", ts_value, 32'h0);
    tick();
    chk("abort_no_done_late", done, 1'b0);
    chk("abort_idle", busy, 1'b0);
    run_check(ID_W, TS_W, 0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'hAA55AA55, system ID value expected at word offset 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h5D1BC64E, build timestamp expected at word offset 1.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address of the sysid slave.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum cycles allowed per read phase (range 2..65535).
REQ-005 SHALL run on one clock; reset is asynchronous and active-high.
REQ-006 clock  input  1  system clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 start  input  1  request a check; sampled on rising edge.
REQ-009 avm_address  output  32  byte address (BASE_ADDR or BASE_ADDR+4).
REQ-010 avm_read  output  1  Avalon-MM read request.
REQ-011 avm_waitrequest  input  1  slave stall; command accepted when avm_read=1 and avm_waitrequest=0.
REQ-012 avm_readdata  input  32  read data.
REQ-013 avm_readdatavalid  input  1  avm_readdata valid this cycle.
REQ-014 busy  output  1  check in progress.
REQ-015 done  output  1  one-cycle pulse at check completion.
REQ-016 id_ok / ts_ok  output  1 each  captured word equals EXPECTED_ID / EXPECTED_TS.
REQ-017 id_value / ts_value  output  32 each  captured words.
REQ-018 timeout  output  1  last check aborted by timeout.

Function
REQ-019 SHALL implement states IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
REQ-020 IDLE: start=1 -> RD_ID; clears id_ok, ts_ok, timeout, id_value, ts_value; busy=1 from the next cycle.
REQ-021 RD_ID/RD_TS: avm_read=1, avm_address=BASE_ADDR / BASE_ADDR+4, held stable until accepted; on accept -> WAIT_ID / WAIT_TS, avm_read=0 in the next cycle.
REQ-022 WAIT_ID: on avm_readdatavalid, capture id_value and id_ok=(data==EXPECTED_ID) -> RD_TS; WAIT_TS: same for ts_value/ts_ok -> DONE.
REQ-023 DONE: done=1 and busy=0 for exactly one cycle -> IDLE; result outputs held until the next accepted start.
REQ-024 avm_readdatavalid outside WAIT_ID/WAIT_TS SHALL be ignored (stray responses after abort).
REQ-025 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-026 Per-phase 16-bit cycle counter cleared on entry to RD_ID and RD_TS, incrementing in RD_*/WAIT_* states; reaching TIMEOUT_CYCLES -> DONE with timeout=1, avm_read=0 next cycle, id_ok=ts_ok=0.
REQ-027 Timeout in the same cycle as readdatavalid: the data capture SHALL take precedence; no timeout.
REQ-028 Zero-wait slave, one-cycle read latency: done SHALL assert 4 rising edges after the edge that samples start.
REQ-029 id_ok/ts_ok SHALL remain 0 for any phase not completed.

Reset
REQ-030 Reset SHALL force IDLE; avm_read, busy, done, id_ok, ts_ok, timeout = 0; id_value, ts_value = 0; avm_address = BASE_ADDR; counter = 0.
REQ-031 Reset asserted mid-check SHALL abort immediately, with no done pulse; a response arriving after reset release SHALL be ignored.

Configuration
REQ-032 Macro SYSID_CHECK_AUTOSTART_EN defined: after reset release, one check SHALL launch automatically (RD_ID entered on the first rising edge with reset low), as if start were sampled.
REQ-033 Macro undefined: checks SHALL launch only on start; the block stays in IDLE after reset.

Verification
REQ-034 Zero-wait slave returning 32'hAA55AA55 then 32'h5D1BC64E, latency 1, start pulse -> done 4 edges later, id_ok=1, ts_ok=1, timeout=0.
REQ-035 Timestamp word 32'h5D1BC64F -> id_ok=1, ts_ok=0, ts_value=32'h5D1BC64F.
REQ-036 avm_waitrequest high 5 cycles on the ID read -> avm_read and avm_address=BASE_ADDR held stable 6 cycles; the check still passes.
REQ-037 TIMEOUT_CYCLES=8, slave never asserts readdatavalid -> done after 8 cycles in the ID phase, timeout=1, id_ok=ts_ok=0; a late readdatavalid is ignored.
REQ-038 Reset pulse during WAIT_TS, then start -> no done from the aborted check; the new check completes with correct flags.
REQ-039 SYSID_CHECK_AUTOSTART_EN defined, no start -> avm_read at BASE_ADDR asserted on the first edge after reset release.
